paddle_arbiter: RTL and testbench

PADDLE_ARBITER -- requirements
Module: paddle_arbiter

---
 rtl/paddle_arbiter_pkg.sv | 48 ++++
 rtl/quad_phase_gen.sv | 46 ++++
 rtl/paddle_arbiter.sv | 115 +++++++++++
 tb/tb_paddle_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/paddle_arbiter_pkg.sv
// Shared types and Gray-code helpers for the two-player paddle arbiter.
// One owner at a time drives the single quadrature encoder input.
package paddle_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_P1   = 2'b01,
    OWNER_P2   = 2'b10
  } owner_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_OWN_P1 = 2'b01,
    ST_OWN_P2 = 2'b10
  } state_e;

  // Pressing both buttons cancels out, same as pressing neither.
  function automatic dir_e decode_dir(input logic left, input logic right);
    if (left && !right) return DIR_LEFT;
    if (right && !left) return DIR_RIGHT;
    return DIR_NONE;
  endfunction

  function automatic logic [1:0] gray_next(input logic [1:0] ph);
    case (ph)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] gray_prev(input logic [1:0] ph);
    case (ph)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/quad_phase_gen.sv
// Free-running step-tick divider plus a 2-bit Gray quadrature stepper.
// Phase moves at most one step per tick, only when step_en_i is high.
module quad_phase_gen
  import paddle_arbiter_pkg::*;
#(
  parameter int unsigned CLKDIV = 5500
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       step_en_i,
  input  dir_e       dir_i,
  output logic       tick_o,
  output logic [1:0] phase_o
);

  localparam logic [15:0] LAST_CNT = 16'(CLKDIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic        tick;

  assign tick = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;
    phase_d = phase_q;
    if (tick && step_en_i) begin
      if (dir_i == DIR_RIGHT)     phase_d = gray_next(phase_q);
      else if (dir_i == DIR_LEFT) phase_d = gray_prev(phase_q);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q   <= 16'd0;
      phase_q <= 2'b00;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign tick_o  = tick;
  assign phase_o = phase_q;

endmodule

// File: rtl/paddle_arbiter.sv
// Grants the shared steering encoder to one player at a time, round-robin on ties,
// releasing ownership after HOLD idle step ticks; owner updates one cycle after a request.
module paddle_arbiter
  import paddle_arbiter_pkg::*;
#(
  parameter int unsigned CLKDIV = 5500,
  parameter int unsigned HOLD   = 32
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       enable,
  input  logic       p1_left,
  input  logic       p1_right,
  input  logic       p2_left,
  input  logic       p2_right,
  output logic [1:0] steer,
  output logic [1:0] owner,
  output logic       tick
);

  localparam logic [7:0] HOLD_CNT = 8'(HOLD);

  state_e     state_q, state_d;
  owner_e     last_q, last_d;
  logic [7:0] idle_q, idle_d, idle_inc;
  dir_e       p1_dir, p2_dir, own_dir;
  logic       step_en;
  logic       tick_w;

  assign p1_dir   = decode_dir(p1_left, p1_right);
  assign p2_dir   = decode_dir(p2_left, p2_right);
  assign idle_inc = idle_q + 8'd1;

  // Non-owner inputs never reach the stepper or the idle counter.
  assign own_dir = (state_q == ST_OWN_P1) ? p1_dir :
                   (state_q == ST_OWN_P2) ? p2_dir : DIR_NONE;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= OWNER_P2;
      idle_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idle_d  = idle_q;
    if (!enable) begin
      state_d = ST_IDLE;
      idle_d  = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idle_d = 8'd0;
          if (p1_dir != DIR_NONE && p2_dir != DIR_NONE) begin
            state_d = (last_q == OWNER_P2) ? ST_OWN_P1 : ST_OWN_P2;
            last_d  = (last_q == OWNER_P2) ? OWNER_P1 : OWNER_P2;
          end else if (p1_dir != DIR_NONE) begin
            state_d = ST_OWN_P1;
            last_d  = OWNER_P1;
          end else if (p2_dir != DIR_NONE) begin
            state_d = ST_OWN_P2;
            last_d  = OWNER_P2;
          end
        end
        ST_OWN_P1, ST_OWN_P2: begin
          if (own_dir != DIR_NONE) begin
            idle_d = 8'd0;
          end else if (tick_w) begin
            if (idle_inc == HOLD_CNT) begin
              state_d = ST_IDLE;
              idle_d  = 8'd0;
            end else begin
              idle_d = idle_inc;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          idle_d  = 8'd0;
        end
      endcase
    end
  end

  // Stepping only from a registered OWN state, so a grant-cycle tick never steps.
  always_comb begin
    step_en = enable && (state_q != ST_IDLE);
    case (state_q)
      ST_OWN_P1: owner = OWNER_P1;
      ST_OWN_P2: owner = OWNER_P2;
      default:   owner = OWNER_NONE;
    endcase
  end

  quad_phase_gen #(
    .CLKDIV(CLKDIV)
  ) u_phase (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .step_en_i(step_en),
    .dir_i    (own_dir),
    .tick_o   (tick_w),
    .phase_o  (steer)
  );

  assign tick = tick_w;

endmodule

// File: tb/tb_paddle_arbiter.sv
// Directed bench for paddle_arbiter at CLKDIV=4, HOLD=2; inputs driven and outputs
// sampled on the falling edge, cycle numbers counted from the reset edge.
module tb_paddle_arbiter;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       p1_left = 1'b0, p1_right = 1'b0;
  logic       p2_left = 1'b0, p2_right = 1'b0;
  logic [1:0] steer, owner;
  logic       tick;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_sys = ~clk_sys;

  paddle_arbiter #(
    .CLKDIV(4),
    .HOLD  (2)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .enable  (enable),
    .p1_left (p1_left),
    .p1_right(p1_right),
    .p2_left (p2_left),
    .p2_right(p2_right),
    .steer   (steer),
    .owner   (owner),
    .tick    (tick)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  // Leaves the bench at the falling edge after the reset edge: divider count is 0.
  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1; enable = 1'b1;
    p1_left = 1'b0; p1_right = 1'b0; p2_left = 1'b0; p2_right = 1'b0;
    adv(1);
    reset = 1'b0;
  endtask

  initial begin
    // Single player stepping right, then release after two idle ticks
    do_reset();
    check("rst_owner", owner, 2'b00);
    check("rst_steer", steer, 2'b00);
    check("rst_tick", tick, 1'b0);
    p1_right = 1'b1;
    adv(1);  check("t1_owner_p1", owner, 2'b01);
    adv(1);  check("t1_tick_lo", tick, 1'b0);
    adv(1);  check("t1_tick_hi", tick, 1'b1);
             check("t1_steer_pre", steer, 2'b00);
    adv(1);  check("t1_steer_01", steer, 2'b01);
             check("t1_tick_lo2", tick, 1'b0);
    adv(4);  check("t1_steer_11", steer, 2'b11);
    adv(4);  check("t1_steer_10", steer, 2'b10);
    adv(4);  check("t1_steer_00", steer, 2'b00);
    adv(4);  check("t1_steer_wrap", steer, 2'b01);
    p1_right = 1'b0;
    adv(7);  check("t1_hold_owner", owner, 2'b01);
    adv(1);  check("t1_release", owner, 2'b00);
             check("t1_steer_kept", steer, 2'b01);

    // Tie from reset goes to P1, next tie to P2
    do_reset();
    p1_right = 1'b1; p2_right = 1'b1;
    adv(1);  check("t2_tie1_p1", owner, 2'b01);
    p1_right = 1'b0; p2_right = 1'b0;
    adv(6);  check("t2_hold", owner, 2'b01);
    adv(1);  check("t2_idle", owner, 2'b00);
             check("t2_no_step", steer, 2'b00);
    p1_left = 1'b1; p2_left = 1'b1;
    adv(1);  check("t2_tie2_p2", owner, 2'b10);
    adv(3);  check("t2_p2_left", steer, 2'b10);

    // P2 waits while P1 idles out, then takes over from the retained phase
    do_reset();
    p1_right = 1'b1;
    adv(1);  check("t3_owner_p1", owner, 2'b01);
    adv(3);  check("t3_steer_01", steer, 2'b01);
    p1_right = 1'b0; p2_left = 1'b1;
    adv(4);  check("t3_own_tick1", owner, 2'b01);
             check("t3_p2_ignored", steer, 2'b01);
    adv(3);  check("t3_own_pre2", owner, 2'b01);
    adv(1);  check("t3_idle", owner, 2'b00);
    adv(1);  check("t3_owner_p2", owner, 2'b10);
             check("t3_retained", steer, 2'b01);
    adv(3);  check("t3_back_00", steer, 2'b00);
    adv(4);  check("t3_back_10", steer, 2'b10);

    // Both P1 buttons: no direction, no step, released after two ticks
    do_reset();
    p1_right = 1'b1;
    adv(1);  check("t4_owner_p1", owner, 2'b01);
    p1_left = 1'b1;
    adv(3);  check("t4_no_step", steer, 2'b00);
    adv(3);  check("t4_hold", owner, 2'b01);
    adv(1);  check("t4_release", owner, 2'b00);
             check("t4_steer", steer, 2'b00);

    // Enable drop mid-ownership holds phase, then resumes
    do_reset();
    p1_right = 1'b1;
    adv(8);  check("t5_steer_11", steer, 2'b11);
    enable = 1'b0;
    adv(1);  check("t5_dis_owner", owner, 2'b00);
             check("t5_dis_steer", steer, 2'b11);
    adv(3);  check("t5_dis_tick_steer", steer, 2'b11);
             check("t5_dis_no_grant", owner, 2'b00);
    enable = 1'b1;
    adv(1);  check("t5_regrant", owner, 2'b01);
    adv(2);  check("t5_pre_step", steer, 2'b11);
    adv(1);  check("t5_resume_10", steer, 2'b10);

    // Reset coinciding with a stepping tick
    do_reset();
    p1_right = 1'b1;
    adv(4);  check("t6_steer_01", steer, 2'b01);
    adv(3);  check("t6_tick_hi", tick, 1'b1);
    reset = 1'b1;
    adv(1);  check("t6_rst_steer", steer, 2'b00);
             check("t6_rst_owner", owner, 2'b00);
             check("t6_rst_tick", tick, 1'b0);
    reset = 1'b0;
    adv(1);  check("t6_regrant", owner, 2'b01);
             check("t6_steer_still", steer, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
